// File: rtl/control_store_if.sv
// Bundle of the micro-sequencer / datapath signals around the control store.
// The master side drives the sequencer inputs and consumes the control word;
// the slave side is the control store itself.
interface control_store_if #(
    parameter int COUNT_W = 16
);

    // Sequencer and instruction inputs
    logic [3:0]         next_addr;
    logic [6:0]         op;
    logic               mem_ready;

    // Sequencer select and micro-PC view
    logic [2:0]         addr_ctl;
    logic [3:0]         curr_addr;

    // Datapath strobes and selects
    logic               pc_update;
    logic               branch;
    logic               reg_write;
    logic               mem_write;
    logic               ir_write;
    logic               adr_src;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;

    // Status
    logic               illegal_op;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output next_addr, op, mem_ready,
        input  addr_ctl, curr_addr,
        input  pc_update, branch, reg_write, mem_write, ir_write, adr_src,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  illegal_op, instr_count
    );

    modport slave (
        input  next_addr, op, mem_ready,
        output addr_ctl, curr_addr,
        output pc_update, branch, reg_write, mem_write, ir_write, adr_src,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output illegal_op, instr_count
    );

endinterface

// File: rtl/control_store.sv
// Microcoded control store for a multicycle RISC-V style datapath.
// A 4-bit micro-PC selects one microword; the external address-select
// sequencer proposes the next microaddress, which is taken except when a
// memory microstep is stalled, an opcode is illegal in Decode, or the
// micro-PC has strayed into the unused range 11..15. Completing microsteps
// (MemWB, MemWrite, ALUWB, BEQ) bump a wrapping retired-instruction counter.
module control_store #(
    parameter int COUNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    control_store_if.slave    cs
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTER  = 4'd6,
        S_ALUWB     = 4'd7,
        S_EXECUTEI  = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } upc_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;

    localparam logic [2:0] AC_INC   = 3'd0;
    localparam logic [2:0] AC_DISP1 = 3'd1;
    localparam logic [2:0] AC_DISP2 = 3'd2;
    localparam logic [2:0] AC_GO0   = 3'd3;
    localparam logic [2:0] AC_GO7   = 3'd4;

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Opcodes the dispatch tables know how to handle.
    function automatic logic op_legal(input logic [6:0] op_v);
        logic legal_v;
        case (op_v)
            OP_RTYPE, OP_ITYPE, OP_JAL,
            OP_BEQ, OP_LW, OP_SW:     legal_v = 1'b1;
            default:                  legal_v = 1'b0;
        endcase
        return legal_v;
    endfunction

    upc_t               upc_r;
    upc_t               upc_next_s;
    upc_t               seq_addr_s;
    logic [COUNT_W-1:0] count_r;
    logic               retire_s;

    logic [2:0]         addr_ctl_s;
    logic               pc_update_s;
    logic               branch_s;
    logic               reg_write_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               adr_src_s;
    logic [1:0]         result_src_s;
    logic [1:0]         alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [1:0]         alu_op_s;
    logic               illegal_op_s;

    assign seq_addr_s = upc_t'(cs.next_addr);

    // Micro-PC and retired-instruction counter; reset wins over stall and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_r   <= S_FETCH;
            count_r <= {COUNT_W{1'b0}};
        end else begin
            upc_r <= upc_next_s;
            if (retire_s) begin
                count_r <= count_r + COUNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Microword decode, stall handling and next micro-PC selection.
    always_comb begin
        upc_next_s   = S_FETCH;
        retire_s     = 1'b0;
        addr_ctl_s   = AC_GO0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        illegal_op_s = 1'b0;

        case (upc_r)
            S_FETCH: begin
                addr_ctl_s   = AC_INC;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                // IR and PC only update once the instruction word has arrived.
                if (cs.mem_ready) begin
                    ir_write_s  = 1'b1;
                    pc_update_s = 1'b1;
                    upc_next_s  = seq_addr_s;
                end else begin
                    upc_next_s  = upc_r;
                end
            end
            S_DECODE: begin
                addr_ctl_s  = AC_DISP1;
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                if (op_legal(cs.op)) begin
                    upc_next_s = seq_addr_s;
                end else begin
                    illegal_op_s = 1'b1;
                    upc_next_s   = S_FETCH;
                end
            end
            S_MEMADR: begin
                addr_ctl_s  = AC_DISP2;
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                upc_next_s  = seq_addr_s;
            end
            S_MEMREAD: begin
                addr_ctl_s = AC_INC;
                adr_src_s  = 1'b1;
                if (cs.mem_ready) begin
                    upc_next_s = seq_addr_s;
                end else begin
                    upc_next_s = upc_r;
                end
            end
            S_MEMWB: begin
                addr_ctl_s   = AC_GO0;
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                upc_next_s   = seq_addr_s;
            end
            S_MEMWRITE: begin
                addr_ctl_s  = AC_GO0;
                adr_src_s   = 1'b1;
                // Write strobe is held for the whole access; it retires on ready.
                mem_write_s = 1'b1;
                if (cs.mem_ready) begin
                    retire_s   = 1'b1;
                    upc_next_s = seq_addr_s;
                end else begin
                    upc_next_s = upc_r;
                end
            end
            S_EXECUTER: begin
                addr_ctl_s  = AC_INC;
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                upc_next_s  = seq_addr_s;
            end
            S_ALUWB: begin
                addr_ctl_s  = AC_GO0;
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                upc_next_s  = seq_addr_s;
            end
            S_EXECUTEI: begin
                addr_ctl_s  = AC_GO7;
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                upc_next_s  = seq_addr_s;
            end
            S_JAL: begin
                addr_ctl_s  = AC_GO7;
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                upc_next_s  = seq_addr_s;
            end
            S_BEQ: begin
                addr_ctl_s  = AC_GO0;
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                retire_s    = 1'b1;
                upc_next_s  = seq_addr_s;
            end
            default: begin
                // Unused microaddresses: everything idle, recover to Fetch.
                addr_ctl_s = AC_GO0;
                upc_next_s = S_FETCH;
            end
        endcase
    end

    assign cs.curr_addr   = upc_r;
    assign cs.instr_count = count_r;
    assign cs.addr_ctl    = addr_ctl_s;
    assign cs.pc_update   = pc_update_s;
    assign cs.branch      = branch_s;
    assign cs.reg_write   = reg_write_s;
    assign cs.mem_write   = mem_write_s;
    assign cs.ir_write    = ir_write_s;
    assign cs.adr_src     = adr_src_s;
    assign cs.result_src  = result_src_s;
    assign cs.alu_src_a   = alu_src_a_s;
    assign cs.alu_src_b   = alu_src_b_s;
    assign cs.alu_op      = alu_op_s;
    assign cs.illegal_op  = illegal_op_s;

endmodule

// File: tb/tb_control_store.sv
// Self-checking bench for control_store: directed microprogram walks plus a
// randomized run, all compared against a table-driven reference model.
module tb_control_store;

    localparam int CW = 8;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Observed-word bit positions
    localparam int B_PCU = 14;
    localparam int B_RW  = 12;
    localparam int B_MW  = 11;
    localparam int B_IRW = 10;
    localparam int B_ADR = 9;
    localparam int B_ILL = 0;

    logic clk = 1'b0;
    logic reset;

    control_store_if #(.COUNT_W(CW)) cs();

    control_store #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_upc    = 0;
    int m_cnt    = 0;

    int seq_r  [5] = '{0, 1, 6, 7, 0};
    int seq_lw [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    int mr_lw  [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int seq_sw [9] = '{0, 0, 0, 1, 2, 5, 5, 5, 0};
    int mr_sw  [8] = '{0, 0, 1, 1, 1, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_JAL) ||
               (o == OP_BEQ) || (o == OP_LW) || (o == OP_SW);
    endfunction

    // Model of the external address-select sequencer.
    function automatic logic [3:0] seq_next(input int upc, input logic [2:0] ac, input logic [6:0] o);
        logic [3:0] r;
        case (ac)
            3'd0: r = 4'(upc + 1);
            3'd1: begin
                if (o == OP_R)                     r = 4'd6;
                else if (o == OP_I)                r = 4'd8;
                else if (o == OP_JAL)              r = 4'd9;
                else if (o == OP_BEQ)              r = 4'd10;
                else if (o == OP_LW || o == OP_SW) r = 4'd2;
                else                               r = 4'd6;
            end
            3'd2:    r = (o == OP_SW) ? 4'd5 : 4'd3;
            3'd4:    r = 4'd7;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [17:0] mk(input int ac, input int pcu, input int br, input int rw,
                                       input int mw, input int irw, input int adr, input int rs,
                                       input int asa, input int asb, input int aop, input int ill);
        return {3'(ac), 1'(pcu), 1'(br), 1'(rw), 1'(mw), 1'(irw), 1'(adr),
                2'(rs), 2'(asa), 2'(asb), 2'(aop), 1'(ill)};
    endfunction

    // Expected control word from the microprogram listing.
    function automatic logic [17:0] exp_word(input int upc, input logic [6:0] o, input logic mr);
        int m;
        m = mr ? 1 : 0;
        case (upc)
            0:       return mk(0, m, 0, 0, 0, m, 0, 2, 0, 2, 0, 0);
            1:       return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, is_legal(o) ? 0 : 1);
            2:       return mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
            3:       return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            4:       return mk(3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
            5:       return mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
            6:       return mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
            7:       return mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            8:       return mk(4, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0);
            9:       return mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
            10:      return mk(3, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0);
            default: return mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    // One clock: drive inputs, check the control word, then check state after the edge.
    task automatic cycle(input logic [6:0] o, input logic mr, input logic rst,
                         input logic garbage, output logic [17:0] seen);
        logic [17:0] ew;
        logic [3:0]  na;
        int          nu;
        int          nc;
        @(negedge clk);
        ew = exp_word(m_upc, o, mr);
        na = garbage ? 4'($urandom_range(0, 15)) : seq_next(m_upc, ew[17:15], o);
        cs.op        = o;
        cs.mem_ready = mr;
        cs.next_addr = na;
        reset        = rst;
        #1;
        seen = {cs.addr_ctl, cs.pc_update, cs.branch, cs.reg_write, cs.mem_write,
                cs.ir_write, cs.adr_src, cs.result_src, cs.alu_src_a, cs.alu_src_b,
                cs.alu_op, cs.illegal_op};
        check("word", 32'(seen), 32'(ew));
        if (rst) begin
            nu = 0;
            nc = 0;
        end else begin
            nc = m_cnt;
            if ((m_upc == 0 || m_upc == 3 || m_upc == 5) && !mr)  nu = m_upc;
            else if (m_upc == 1 && !is_legal(o))                 nu = 0;
            else if (m_upc > 10)                                 nu = 0;
            else                                                 nu = int'(na);
            if (m_upc == 4 || m_upc == 7 || m_upc == 10 || (m_upc == 5 && mr))
                nc = (m_cnt + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
        m_upc = nu;
        m_cnt = nc;
        check("upc", 32'(cs.curr_addr), 32'(m_upc));
        check("count", 32'(cs.instr_count), 32'(m_cnt));
    endtask

    initial begin
        logic [17:0] w;
        logic [6:0]  ro;

        reset        = 1'b1;
        cs.op        = OP_R;
        cs.mem_ready = 1'b1;
        cs.next_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        m_upc = 0;
        m_cnt = 0;
        check("rst_upc", 32'(cs.curr_addr), 32'd0);
        check("rst_cnt", 32'(cs.instr_count), 32'd0);
        check("rst_ac", 32'(cs.addr_ctl), 32'd0);
        check("rst_irw", 32'(cs.ir_write), 32'd1);

        // R-type: 0,1,6,7,0 with reg_write only in ALUWB
        cycle(OP_R, 1'b1, 1'b1, 1'b0, w);
        for (int i = 0; i < 4; i++) begin
            check("r_upc", 32'(cs.curr_addr), 32'(seq_r[i]));
            cycle(OP_R, 1'b1, 1'b0, 1'b0, w);
            check("r_regwrite", 32'(w[B_RW]), (seq_r[i] == 7) ? 32'd1 : 32'd0);
        end
        check("r_upc_end", 32'(cs.curr_addr), 32'd0);
        check("r_count", 32'(cs.instr_count), 32'd1);

        // Load with a 3-cycle stall in MemRead
        for (int i = 0; i < 8; i++) begin
            check("lw_upc", 32'(cs.curr_addr), 32'(seq_lw[i]));
            cycle(OP_LW, 1'(mr_lw[i]), 1'b0, 1'b0, w);
            if (seq_lw[i] == 3) check("lw_adrsrc", 32'(w[B_ADR]), 32'd1);
        end
        check("lw_upc_end", 32'(cs.curr_addr), 32'd0);
        check("lw_count", 32'(cs.instr_count), 32'd2);

        // Store with a 2-cycle Fetch stall and a 2-cycle MemWrite stall
        for (int i = 0; i < 8; i++) begin
            check("sw_upc", 32'(cs.curr_addr), 32'(seq_sw[i]));
            cycle(OP_SW, 1'(mr_sw[i]), 1'b0, 1'b0, w);
            if (i < 2) begin
                check("sw_irw_stall", 32'(w[B_IRW]), 32'd0);
                check("sw_pcu_stall", 32'(w[B_PCU]), 32'd0);
            end
            if (i == 2) begin
                check("sw_irw_go", 32'(w[B_IRW]), 32'd1);
                check("sw_pcu_go", 32'(w[B_PCU]), 32'd1);
            end
            if (seq_sw[i] == 5) check("sw_memwrite", 32'(w[B_MW]), 32'd1);
        end
        check("sw_count", 32'(cs.instr_count), 32'd3);

        // Illegal opcode in Decode
        cycle(OP_BAD, 1'b1, 1'b0, 1'b0, w);
        check("ill_fetch", 32'(w[B_ILL]), 32'd0);
        check("ill_upc1", 32'(cs.curr_addr), 32'd1);
        cycle(OP_BAD, 1'b1, 1'b0, 1'b0, w);
        check("ill_flag", 32'(w[B_ILL]), 32'd1);
        check("ill_upc0", 32'(cs.curr_addr), 32'd0);
        check("ill_count", 32'(cs.instr_count), 32'd3);

        // Reset while in MemWrite with mem_ready high: no count, back to Fetch
        for (int i = 0; i < 3; i++) cycle(OP_SW, 1'b1, 1'b0, 1'b0, w);
        check("rst5_pre", 32'(cs.curr_addr), 32'd5);
        cycle(OP_SW, 1'b1, 1'b1, 1'b0, w);
        check("rst5_upc", 32'(cs.curr_addr), 32'd0);
        check("rst5_cnt", 32'(cs.instr_count), 32'd0);

        // Counter wrap: 2^CW-1 BEQs then one more
        for (int k = 0; k < (1 << CW) - 1; k++) begin
            for (int j = 0; j < 3; j++) cycle(OP_BEQ, 1'b1, 1'b0, 1'b0, w);
        end
        check("wrap_pre", 32'(cs.instr_count), 32'((1 << CW) - 1));
        for (int j = 0; j < 3; j++) cycle(OP_BEQ, 1'b1, 1'b0, 1'b0, w);
        check("wrap_zero", 32'(cs.instr_count), 32'd0);

        // Randomized run: mixed opcodes, stalls, resets and stray microaddresses
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 7))
                0:       ro = OP_R;
                1:       ro = OP_I;
                2:       ro = OP_JAL;
                3:       ro = OP_BEQ;
                4:       ro = OP_LW;
                5:       ro = OP_SW;
                default: ro = 7'($urandom);
            endcase
            cycle(ro, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 15) == 0), w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_store.md
CONTROL_STORE -- requirements
Module: control_store

Interface
REQ-001 Parameter COUNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 next_addr  in  4  next microaddress returned by the address-select sequencer.
REQ-005 op  in  7  opcode field of the instruction register.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 addr_ctl  out  3  sequencer select: 0=+1, 1=dispatch1, 2=dispatch2, 3=go 0, 4=go 7.
REQ-008 curr_addr  out  4  current micro-PC (uPC) register value.
REQ-009 pc_update, branch, reg_write, mem_write, ir_write, adr_src  out  1 each  datapath strobes/selects.
REQ-010 result_src, alu_src_a, alu_src_b, alu_op  out  2 each  datapath selects.
REQ-011 illegal_op  out  1  unsupported opcode seen in Decode.
REQ-012 instr_count  out  COUNT_W  retired-instruction count.

Function
REQ-013 uPC SHALL be a 4-bit register; curr_addr SHALL equal uPC; all other outputs SHALL be combinational from uPC, op and mem_ready.
REQ-014 Microword per uPC (addr_ctl; asserted fields, all unlisted fields 0):
 0 Fetch: 0; ir_write, pc_update, alu_src_b=10, result_src=10.
 1 Decode: 1; alu_src_a=01, alu_src_b=01.
 2 MemAdr: 2; alu_src_a=10, alu_src_b=01.
 3 MemRead: 0; adr_src.
 4 MemWB: 3; result_src=01, reg_write.
 5 MemWrite: 3; adr_src, mem_write.
 6 ExecuteR: 0; alu_src_a=10, alu_op=10.
 7 ALUWB: 3; reg_write.
 8 ExecuteI: 4; alu_src_a=10, alu_src_b=01, alu_op=10.
 9 JAL: 4; alu_src_a=01, alu_src_b=10, pc_update.
 10 BEQ: 3; alu_src_a=10, alu_op=01, branch.
REQ-015 Memory states {0,3,5}: while mem_ready=0, uPC SHALL hold; in state 0 ir_write and pc_update SHALL be 0 while stalled; in state 5 mem_write SHALL stay 1 until mem_ready=1.
REQ-016 In all other states uPC SHALL load next_addr every cycle (latency 1 cycle per microstep).
REQ-017 In Decode, if op is not one of 0110011, 0010011, 1101111, 1100011, 0000011, 0100011, illegal_op SHALL be 1 that cycle and uPC SHALL load 0 instead of next_addr.
REQ-018 uPC values 11-15 SHALL drive addr_ctl=3, all strobes/selects 0, and load 0 next cycle regardless of next_addr.
REQ-019 instr_count SHALL increment by 1 on each cycle where uPC in {4,5,7,10} advances (state 5 only with mem_ready=1); illegal ops SHALL not count.
REQ-020 instr_count SHALL wrap from 2^COUNT_W-1 to 0.

Reset
REQ-021 reset=1 SHALL set uPC=0 and instr_count=0 at the next rising edge, overriding stall, dispatch and count in the same cycle.
REQ-022 After reset, outputs SHALL show the Fetch microword; reset mid-instruction SHALL abandon it without counting.

Verification
REQ-023 reset, op=0110011, mem_ready=1, model sequencer -> uPC 0,1,6,7,0; reg_write=1 only at uPC 7; instr_count=1.
REQ-024 op=0000011, mem_ready low 3 cycles in MemRead -> uPC 0,1,2,3,3,3,3,4,0; adr_src=1 throughout state 3; count+1.
REQ-025 op=0100011, mem_ready=0 two cycles in Fetch -> ir_write=pc_update=0 for 2 cycles then 1; mem_write held in state 5 until ready.
REQ-026 op=1111111 at Decode -> illegal_op=1 one cycle, uPC 1->0, instr_count unchanged.
REQ-027 instr_count preloaded to 16'hFFFF via 65535 BEQ ops -> one more BEQ gives 0.
REQ-028 reset asserted with uPC=5 and mem_ready=1 -> uPC=0, instr_count=0 next edge; no count increment.
